// File: rtl/fetch_stage_pkg.sv
// Shared RV32I fetch definitions: opcodes, special encodings, FSM states and IF/ID layout.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
  } if_id_t;

  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.valid      = 1'b0;
    b.pc         = 32'h0000_0000;
    b.instr      = INSTR_NOP;
    b.pred_taken = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: text memory port, hazard/redirect controls and the IF/ID register outputs.
interface fetch_stage_if #(
  parameter int IMEM_AW = 10
) ();

  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               if_id_valid;
  logic [31:0]        if_id_pc;
  logic [31:0]        if_id_instr;
  logic               if_id_pred_taken;
  logic               halted;
  logic [7:0]         fetch_count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output if_id_valid,
    output if_id_pc,
    output if_id_instr,
    output if_id_pred_taken,
    output halted,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output redirect,
    output redirect_pc,
    input  if_id_valid,
    input  if_id_pc,
    input  if_id_instr,
    input  if_id_pred_taken,
    input  halted,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_stage_predecode.sv
// Static predictor: JAL and backward branches are predicted taken toward their immediate target.
module fetch_predecode
  import fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_target
);

  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_b;

  assign w_imm_j = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign w_imm_b = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};

  // Select prediction and target from the opcode
  always_comb begin
    o_pred_taken = 1'b0;
    o_target     = i_pc + 32'd4;
    case (i_instr[6:0])
      OPC_JAL: begin
        o_pred_taken = 1'b1;
        o_target     = i_pc + w_imm_j;
      end
      OPC_BRANCH: begin
        if (i_instr[31]) begin
          o_pred_taken = 1'b1;
          o_target     = i_pc + w_imm_b;
        end else begin
          o_pred_taken = 1'b0;
          o_target     = i_pc + 32'd4;
        end
      end
      default: begin
        o_pred_taken = 1'b0;
        o_target     = i_pc + 32'd4;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: pc, BOOT/RUN/HALT FSM and IF/ID register.
// Optional static branch prediction is enabled by defining STATIC_PREDICT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  if_id_t          r_if_id;
  logic            r_halted;
  logic [7:0]      r_count;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_next_pc;
  logic            w_pred_taken;

  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef STATIC_PREDICT_EN
  logic [XLEN-1:0] w_pred_target;

  fetch_predecode u_predecode (
    .i_instr      (bus.imem_rdata),
    .i_pc         (r_pc),
    .o_pred_taken (w_pred_taken),
    .o_target     (w_pred_target)
  );

  assign w_next_pc = w_pred_taken ? w_pred_target : w_pc_plus4;
`else
  assign w_pred_taken = 1'b0;
  assign w_next_pc    = w_pc_plus4;
`endif

  // Redirect outranks everything, including stall and HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_PC;
      r_if_id  <= if_id_bubble();
      r_halted <= 1'b0;
      r_count  <= 8'd0;
    end else if (bus.redirect) begin
      r_state  <= ST_RUN;
      r_pc     <= {bus.redirect_pc[31:2], 2'b00};
      r_if_id  <= if_id_bubble();
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
          r_if_id <= if_id_bubble();
        end
        ST_HALT: begin
          r_if_id <= if_id_bubble();
        end
        ST_RUN: begin
          if (!bus.stall) begin
            r_if_id.valid      <= 1'b1;
            r_if_id.pc         <= r_pc;
            r_if_id.instr      <= bus.imem_rdata;
            r_if_id.pred_taken <= w_pred_taken;
            r_pc               <= w_next_pc;
            r_count            <= r_count + 8'd1;
            if (bus.imem_rdata == INSTR_EBREAK) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= ST_BOOT;
          r_pc     <= RESET_PC;
          r_if_id  <= if_id_bubble();
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr        = r_pc[IMEM_AW+1:2];
  assign bus.if_id_valid      = r_if_id.valid;
  assign bus.if_id_pc         = r_if_id.pc;
  assign bus.if_id_instr      = r_if_id.instr;
  assign bus.if_id_pred_taken = r_if_id.pred_taken;
  assign bus.halted           = r_halted;
  assign bus.fetch_count      = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (prediction checks follow STATIC_PREDICT_EN).
module tb_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] JAL_P16  = 32'h0100_006F;
  localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;
  localparam logic [31:0] BEQ_P8   = 32'h0000_0463;
`ifdef STATIC_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [31:0] mem [0:1023];
  int n_checks;
  int n_fail;

  fetch_stage_if #(.IMEM_AW(10)) bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_rdata = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 1024; i++) mem[i] = NOP;
  endtask

  task automatic do_reset();
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_and_fetch();
    fill_nop();
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    rst = 1'b1;
    #2;
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", bus.if_id_valid); end
    n_checks++; if (bus.if_id_instr !== NOP) begin n_fail++; $display("FAIL rst_instr got %h exp %h", bus.if_id_instr, NOP); end
    n_checks++; if (bus.if_id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", bus.if_id_pc); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b exp 0", bus.halted); end
    n_checks++; if (bus.fetch_count !== 8'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", bus.fetch_count); end
    n_checks++; if (bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", bus.imem_addr); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b exp 0", bus.if_id_valid); end
    n_checks++; if (bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL boot_addr got %h exp 0", bus.imem_addr); end
    tick();
    n_checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 32'h0) begin n_fail++; $display("FAIL fetch0 got v=%b pc=%h exp v=1 pc=0", bus.if_id_valid, bus.if_id_pc); end
    tick();
    n_checks++; if (bus.if_id_pc !== 32'h4 || bus.if_id_instr !== 32'h0010_0093) begin n_fail++; $display("FAIL fetch4 got pc=%h ins=%h exp pc=4 ins=00100093", bus.if_id_pc, bus.if_id_instr); end
    tick();
    n_checks++; if (bus.if_id_pc !== 32'h8 || bus.if_id_instr !== 32'h0020_0113) begin n_fail++; $display("FAIL fetch8 got pc=%h ins=%h exp pc=8 ins=00200113", bus.if_id_pc, bus.if_id_instr); end
    n_checks++; if (bus.fetch_count !== 8'd3) begin n_fail++; $display("FAIL fetch_count got %0d exp 3", bus.fetch_count); end
    n_checks++; if (bus.imem_addr !== 10'd3) begin n_fail++; $display("FAIL fetch_addr got %h exp 3", bus.imem_addr); end
  endtask

  task automatic test_stall();
    fill_nop();
    do_reset();
    tick(); tick(); tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.if_id_pc !== 32'h4 || bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_ifid got v=%b pc=%h exp v=1 pc=4", bus.if_id_valid, bus.if_id_pc); end
      n_checks++; if (bus.imem_addr !== 10'd2) begin n_fail++; $display("FAIL stall_pc got %h exp 2", bus.imem_addr); end
      n_checks++; if (bus.fetch_count !== 8'd2) begin n_fail++; $display("FAIL stall_count got %0d exp 2", bus.fetch_count); end
    end
    bus.stall = 1'b0;
    tick();
    n_checks++; if (bus.if_id_pc !== 32'h8 || bus.fetch_count !== 8'd3) begin n_fail++; $display("FAIL stall_resume got pc=%h cnt=%0d exp pc=8 cnt=3", bus.if_id_pc, bus.fetch_count); end
  endtask

  task automatic test_redirect_under_stall();
    fill_nop();
    mem[64] = 32'h0050_0293;
    do_reset();
    tick(); tick(); tick();
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick();
    n_checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP || bus.if_id_pc !== 32'h0) begin n_fail++; $display("FAIL redir_bubble got v=%b ins=%h pc=%h exp v=0 ins=00000013 pc=0", bus.if_id_valid, bus.if_id_instr, bus.if_id_pc); end
    n_checks++; if (bus.imem_addr !== 10'h040) begin n_fail++; $display("FAIL redir_pc got %h exp 040", bus.imem_addr); end
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    tick();
    n_checks++; if (bus.if_id_pc !== 32'h100 || bus.if_id_valid !== 1'b1 || bus.if_id_instr !== 32'h0050_0293) begin n_fail++; $display("FAIL redir_target got v=%b pc=%h ins=%h exp v=1 pc=100 ins=00500293", bus.if_id_valid, bus.if_id_pc, bus.if_id_instr); end
    n_checks++; if (bus.fetch_count !== 8'd3) begin n_fail++; $display("FAIL redir_count got %0d exp 3", bus.fetch_count); end
  endtask

  task automatic test_ebreak();
    fill_nop();
    mem[3] = EBREAK;
    do_reset();
    tick(); tick(); tick(); tick();
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL pre_halt got %b exp 0", bus.halted); end
    tick();
    n_checks++; if (bus.halted !== 1'b1 || bus.if_id_instr !== EBREAK || bus.if_id_pc !== 32'hC) begin n_fail++; $display("FAIL halt_capture got h=%b ins=%h pc=%h exp h=1 ins=00100073 pc=c", bus.halted, bus.if_id_instr, bus.if_id_pc); end
    tick(); tick();
    n_checks++; if (bus.if_id_valid !== 1'b0 || bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold got v=%b h=%b exp v=0 h=1", bus.if_id_valid, bus.halted); end
    n_checks++; if (bus.imem_addr !== 10'd4 || bus.fetch_count !== 8'd4) begin n_fail++; $display("FAIL halt_pc got addr=%h cnt=%0d exp addr=4 cnt=4", bus.imem_addr, bus.fetch_count); end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    n_checks++; if (bus.halted !== 1'b0 || bus.imem_addr !== 10'h010) begin n_fail++; $display("FAIL halt_exit got h=%b addr=%h exp h=0 addr=010", bus.halted, bus.imem_addr); end
    tick();
    n_checks++; if (bus.if_id_pc !== 32'h40 || bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL halt_refetch got v=%b pc=%h exp v=1 pc=40", bus.if_id_valid, bus.if_id_pc); end
  endtask

  task automatic test_ebreak_stalled();
    fill_nop();
    mem[3] = EBREAK;
    do_reset();
    tick(); tick(); tick(); tick();
    bus.stall = 1'b1;
    tick(); tick();
    n_checks++; if (bus.halted !== 1'b0 || bus.if_id_pc !== 32'h8) begin n_fail++; $display("FAIL stall_ebreak got h=%b pc=%h exp h=0 pc=8", bus.halted, bus.if_id_pc); end
    bus.stall = 1'b0;
    tick();
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL stall_ebreak_release got %b exp 1", bus.halted); end
  endtask

  task automatic test_predict();
    fill_nop();
    mem[8]  = JAL_P16;
    mem[16] = BEQ_M8;
    mem[20] = BEQ_P8;
    do_reset();
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h20;
    tick();
    bus.redirect = 1'b0;
    tick();
    n_checks++; if (bus.if_id_pc !== 32'h20 || bus.if_id_pred_taken !== PRED) begin n_fail++; $display("FAIL jal_pred got pc=%h p=%b exp pc=20 p=%b", bus.if_id_pc, bus.if_id_pred_taken, PRED); end
    tick();
    n_checks++; if (bus.if_id_pc !== (PRED ? 32'h30 : 32'h24)) begin n_fail++; $display("FAIL jal_target got %h exp %h", bus.if_id_pc, PRED ? 32'h30 : 32'h24); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    tick();
    n_checks++; if (bus.if_id_pred_taken !== PRED || bus.imem_addr !== (PRED ? 10'd14 : 10'd17)) begin n_fail++; $display("FAIL beq_back got p=%b addr=%h exp p=%b addr=%h", bus.if_id_pred_taken, bus.imem_addr, PRED, PRED ? 10'd14 : 10'd17); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h50;
    tick();
    bus.redirect = 1'b0;
    tick();
    n_checks++; if (bus.if_id_pred_taken !== 1'b0 || bus.imem_addr !== 10'd21) begin n_fail++; $display("FAIL beq_fwd got p=%b addr=%h exp p=0 addr=015", bus.if_id_pred_taken, bus.imem_addr); end
  endtask

  task automatic test_count_wrap_and_async_reset();
    fill_nop();
    do_reset();
    tick();
    for (int i = 0; i < 255; i++) tick();
    n_checks++; if (bus.fetch_count !== 8'd255) begin n_fail++; $display("FAIL count_255 got %0d exp 255", bus.fetch_count); end
    tick();
    n_checks++; if (bus.fetch_count !== 8'd0) begin n_fail++; $display("FAIL count_wrap got %0d exp 0", bus.fetch_count); end
    do_reset();
    tick();
    for (int i = 0; i < 32; i++) tick();
    n_checks++; if (bus.imem_addr !== 10'h020 || bus.fetch_count !== 8'd32) begin n_fail++; $display("FAIL mid_pc got addr=%h cnt=%0d exp addr=020 cnt=32", bus.imem_addr, bus.fetch_count); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.imem_addr !== 10'd0 || bus.fetch_count !== 8'd0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL async_rst_a got addr=%h cnt=%0d h=%b exp 0 0 0", bus.imem_addr, bus.fetch_count, bus.halted); end
    n_checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_pc !== 32'h0 || bus.if_id_instr !== NOP || bus.if_id_pred_taken !== 1'b0) begin n_fail++; $display("FAIL async_rst_b got v=%b pc=%h ins=%h p=%b exp bubble", bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, bus.if_id_pred_taken); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset_and_fetch();
    test_stall();
    test_redirect_under_stall();
    test_ebreak();
    test_ebreak_stalled();
    test_predict();
    test_count_wrap_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
